msg_stream_tx: RTL

- Parametrised message source for the UART transmit path.
- Streams a compile-time message one character at a time into the transmitter over a valid/ready handshake.
- Supports single-shot (start pulse) and auto-repeat operation, with a programmable idle gap between repeats.
- Sits between the board switches/buttons and the UART transmitter; replaces the fixed 12-character, fixed-gap message driver.

---
 rtl/msg_stream_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/msg_stream_tx.sv
`timescale 1ns/1ps
// msg_stream_tx
// Streams a compile-time message, one character per handshake, into the UART
// transmitter over valid/ready. Single-shot on a start pulse, or auto-repeat
// with a GAP_CYCLES idle gap between messages.
// Build option: define MSG_STREAM_CRLF_EN to append CR (0x0D), LF (0x0A).
module msg_stream_tx #(
  parameter int                        MSG_LEN    = 12,
  parameter int                        CHAR_W     = 8,
  parameter logic [MSG_LEN*CHAR_W-1:0] MSG        = "hello world!",
  parameter int                        GAP_CYCLES = 15000,
  parameter int                        IDX_W      = $clog2(MSG_LEN + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              repeat_mode,
  input  logic              start,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [CHAR_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  char_idx
);

`ifdef MSG_STREAM_CRLF_EN
  localparam int TOTAL = MSG_LEN + 2;
`else
  localparam int TOTAL = MSG_LEN;
`endif
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [CHAR_W-1:0]  data_q,  data_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               stop_q,  stop_d;
  logic               accept, last, stopping;

  // Character at position idx of the full stream (message plus optional CR/LF).
  function automatic logic [CHAR_W-1:0] char_at(input logic [IDX_W-1:0] idx);
    logic [CHAR_W-1:0] c;
    c = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx == IDX_W'(i)) c = MSG[(MSG_LEN-1-i)*CHAR_W +: CHAR_W];
    end
`ifdef MSG_STREAM_CRLF_EN
    if (idx == IDX_W'(MSG_LEN))     c = CHAR_W'(8'h0D);
    if (idx == IDX_W'(MSG_LEN + 1)) c = CHAR_W'(8'h0A);
`endif
    return c;
  endfunction

  // Next-state and next-output logic; outputs are registered from *_d.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    accept   = valid_q & tx_ready;
    last     = (idx_q == IDX_W'(TOTAL - 1));
    stopping = stop_q | ~enable;

    unique case (state_q)
      IDLE: begin
        if (enable && (repeat_mode || start)) begin
          state_d = SEND;
          valid_d = 1'b1;
          idx_d   = '0;
          data_d  = char_at('0);
          stop_d  = 1'b0;
        end
      end
      SEND: begin
        // Once enable drops, the current character still completes, then stop.
        if (!enable) stop_d = 1'b1;
        if (accept) begin
          if (last || stopping) begin
            valid_d = 1'b0;
            idx_d   = '0;
            stop_d  = 1'b0;
            done_d  = last;
            if (last && repeat_mode && !stopping) begin
              state_d = GAP;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = char_at(idx_q + IDX_W'(1));
          end
        end
      end
      GAP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = SEND;
          valid_d = 1'b1;
          idx_d   = '0;
          data_d  = char_at('0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign char_idx = idx_q;

endmodule
